// File: rtl/brent_kung_adder8_pkg.sv
// ----------------------------------------------------------------------------
// bka_pkg
//   Shared definitions for the 8-bit Brent-Kung prefix adder.
//   BKA_WIDTH : fixed operand width (8).
//   gp_t      : generate/propagate pair carried through the prefix tree.
// ----------------------------------------------------------------------------
package bka_pkg;

   localparam int unsigned BKA_WIDTH = 8;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

endpackage : bka_pkg

// File: rtl/brent_kung_adder8_if.sv
// ----------------------------------------------------------------------------
// brent_kung_adder8_if
//   Operand/result bundle of the Brent-Kung adder.
//   A, B   : unsigned addends (BKA_WIDTH bits)
//   Cin    : carry-in
//   Sum    : registered sum bits
//   Cout   : registered carry-out
//   master : the side that supplies operands and reads the result
//   slave  : the adder itself
// ----------------------------------------------------------------------------
interface brent_kung_adder8_if;
   import bka_pkg::*;

   logic [BKA_WIDTH-1:0] A;
   logic [BKA_WIDTH-1:0] B;
   logic                 Cin;
   logic [BKA_WIDTH-1:0] Sum;
   logic                 Cout;

   modport master (
      output A,
      output B,
      output Cin,
      input  Sum,
      input  Cout
   );

   modport slave (
      input  A,
      input  B,
      input  Cin,
      output Sum,
      output Cout
   );

endinterface : brent_kung_adder8_if

// File: rtl/brent_kung_adder8_prefix_cell.sv
// ----------------------------------------------------------------------------
// bk_prefix_cell
//   Combinational prefix "dot" operator:
//   (g_out, p_out) = (g_hi | p_hi & g_lo, p_hi & p_lo)
//   g_hi/p_hi : group signals of the more significant span
//   g_lo/p_lo : group signals of the adjacent less significant span
// ----------------------------------------------------------------------------
module bk_prefix_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);

   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;

endmodule : bk_prefix_cell

// File: rtl/brent_kung_adder8.sv
// ----------------------------------------------------------------------------
// brent_kung_adder8
//   8-bit parallel-prefix adder (Brent-Kung carry network) with a single
//   registered output stage: {Cout, Sum} = A + B + Cin, latency 1 cycle.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears Sum/Cout
//   bus : slave side of brent_kung_adder8_if (A, B, Cin in; Sum, Cout out)
// ----------------------------------------------------------------------------
module brent_kung_adder8
   import bka_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   brent_kung_adder8_if.slave         bus
);

   // Bit-level generate/propagate.
   gp_t [BKA_WIDTH-1:0] bit_gp;

   always_comb begin
      for (int unsigned i = 0; i < BKA_WIDTH; i++) begin
         bit_gp[i].g = bus.A[i] & bus.B[i];
         bit_gp[i].p = bus.A[i] ^ bus.B[i];
      end
   end

   // Cin acts as generate bit g_-1 with p_-1 = 0. Merging it into bit 0 up
   // front makes every span [k:0] below really mean [k:-1], so each group
   // generate is directly the carry into the next bit.
   gp_t s0_0;

   bk_prefix_cell u_cin (
      .g_hi (bit_gp[0].g), .p_hi (bit_gp[0].p),
      .g_lo (bus.Cin),     .p_lo (1'b0),
      .g_out(s0_0.g),      .p_out(s0_0.p)
   );

   // Up-sweep, level 1
   gp_t s1_0, s3_2, s5_4, s7_6;

   bk_prefix_cell u_up1_10 (
      .g_hi (bit_gp[1].g), .p_hi (bit_gp[1].p),
      .g_lo (s0_0.g),      .p_lo (s0_0.p),
      .g_out(s1_0.g),      .p_out(s1_0.p)
   );
   bk_prefix_cell u_up1_32 (
      .g_hi (bit_gp[3].g), .p_hi (bit_gp[3].p),
      .g_lo (bit_gp[2].g), .p_lo (bit_gp[2].p),
      .g_out(s3_2.g),      .p_out(s3_2.p)
   );
   bk_prefix_cell u_up1_54 (
      .g_hi (bit_gp[5].g), .p_hi (bit_gp[5].p),
      .g_lo (bit_gp[4].g), .p_lo (bit_gp[4].p),
      .g_out(s5_4.g),      .p_out(s5_4.p)
   );
   bk_prefix_cell u_up1_76 (
      .g_hi (bit_gp[7].g), .p_hi (bit_gp[7].p),
      .g_lo (bit_gp[6].g), .p_lo (bit_gp[6].p),
      .g_out(s7_6.g),      .p_out(s7_6.p)
   );

   // Up-sweep, level 2
   gp_t s3_0, s7_4;

   bk_prefix_cell u_up2_30 (
      .g_hi (s3_2.g), .p_hi (s3_2.p),
      .g_lo (s1_0.g), .p_lo (s1_0.p),
      .g_out(s3_0.g), .p_out(s3_0.p)
   );
   bk_prefix_cell u_up2_74 (
      .g_hi (s7_6.g), .p_hi (s7_6.p),
      .g_lo (s5_4.g), .p_lo (s5_4.p),
      .g_out(s7_4.g), .p_out(s7_4.p)
   );

   // Up-sweep, level 3
   gp_t s7_0;

   bk_prefix_cell u_up3_70 (
      .g_hi (s7_4.g), .p_hi (s7_4.p),
      .g_lo (s3_0.g), .p_lo (s3_0.p),
      .g_out(s7_0.g), .p_out(s7_0.p)
   );

   // Down-sweep: fill in the spans the up-sweep left out
   gp_t s5_0, s2_0, s4_0, s6_0;

   bk_prefix_cell u_dn_50 (
      .g_hi (s5_4.g), .p_hi (s5_4.p),
      .g_lo (s3_0.g), .p_lo (s3_0.p),
      .g_out(s5_0.g), .p_out(s5_0.p)
   );
   bk_prefix_cell u_dn_20 (
      .g_hi (bit_gp[2].g), .p_hi (bit_gp[2].p),
      .g_lo (s1_0.g),      .p_lo (s1_0.p),
      .g_out(s2_0.g),      .p_out(s2_0.p)
   );
   bk_prefix_cell u_dn_40 (
      .g_hi (bit_gp[4].g), .p_hi (bit_gp[4].p),
      .g_lo (s3_0.g),      .p_lo (s3_0.p),
      .g_out(s4_0.g),      .p_out(s4_0.p)
   );
   bk_prefix_cell u_dn_60 (
      .g_hi (bit_gp[6].g), .p_hi (bit_gp[6].p),
      .g_lo (s5_0.g),      .p_lo (s5_0.p),
      .g_out(s6_0.g),      .p_out(s6_0.p)
   );

   // Carry into bit i is the group generate of span [i-1:-1].
   logic [BKA_WIDTH:0]   carry;
   logic [BKA_WIDTH-1:0] sum_d;

   assign carry = {s7_0.g, s6_0.g, s5_0.g, s4_0.g,
                   s3_0.g, s2_0.g, s1_0.g, s0_0.g, bus.Cin};

   always_comb begin
      for (int unsigned i = 0; i < BKA_WIDTH; i++) begin
         sum_d[i] = bit_gp[i].p ^ carry[i];
      end
   end

   // Output register
   logic [BKA_WIDTH-1:0] sum_q;
   logic                 cout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= carry[BKA_WIDTH];
      end
   end

   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;

endmodule : brent_kung_adder8

// File: tb/tb_brent_kung_adder8.sv
module tb_brent_kung_adder8;
   import bka_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   brent_kung_adder8_if bus ();

   brent_kung_adder8 dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic check_result(input string tag, input logic [8:0] obs,
                               input logic [8:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got {Cout,Sum}=%h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain 9-bit arithmetic.
   function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
      return 9'(a) + 9'(b) + 9'(c);
   endfunction

   // Drive operands between edges, then sample #1 after the next rising edge.
   task automatic apply_check(input string tag, input logic [7:0] a,
                              input logic [7:0] b, input logic c,
                              input logic [8:0] exp);
      @(negedge clk);
      bus.A   = a;
      bus.B   = b;
      bus.Cin = c;
      @(posedge clk);
      #1;
      check_result(tag, {bus.Cout, bus.Sum}, exp);
   endtask

   initial begin
      logic [7:0] a, b;
      logic       c;

      // Reset held for two cycles with the worst-case operands applied.
      bus.A   = 8'hFF;
      bus.B   = 8'hFF;
      bus.Cin = 1'b1;
      rst     = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_result("reset", {bus.Cout, bus.Sum}, 9'h000);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_result("first_after_reset", {bus.Cout, bus.Sum}, 9'h1FF);

      // Directed vectors with hand-computed results.
      apply_check("dir_0d_b0",   8'h0D, 8'hB0, 1'b0, 9'h0BD);
      apply_check("dir_06_99",   8'h06, 8'h99, 1'b0, 9'h09F);
      apply_check("carry_c5_f3", 8'hC5, 8'hF3, 1'b0, 9'h1B8);
      apply_check("carry_7a_a5", 8'h7A, 8'hA5, 1'b1, 9'h120);
      apply_check("prop_cin1",   8'hFF, 8'h00, 1'b1, 9'h100);
      apply_check("prop_cin0",   8'hFF, 8'h00, 1'b0, 9'h0FF);
      apply_check("zero",        8'h00, 8'h00, 1'b0, 9'h000);
      apply_check("max",         8'hFF, 8'hFF, 1'b1, 9'h1FF);

      // Reset asserted while an operation is in flight discards it.
      @(negedge clk);
      bus.A   = 8'h80;
      bus.B   = 8'h80;
      bus.Cin = 1'b1;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      check_result("reset_in_flight", {bus.Cout, bus.Sum}, 9'h000);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_result("after_reset2", {bus.Cout, bus.Sum}, 9'h101);

      // Sweep of small operands, one new operation every cycle.
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            a = 8'(ia);
            b = 8'(ib);
            c = a[0] ^ b[0];
            apply_check("sweep", a, b, c, ref_add(a, b, c));
         end
      end

      // Random vectors.
      for (int n = 0; n < 10000; n++) begin
         a = 8'($urandom_range(255, 0));
         b = 8'($urandom_range(255, 0));
         c = 1'($urandom_range(1, 0));
         apply_check("random", a, b, c, ref_add(a, b, c));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_brent_kung_adder8
